// File: rtl/plru_victim_ctrl_if.sv
// Port bundle between the cache controller and the PLRU victim controller.
// The controller side drives accesses, victim requests and flushes; the PLRU
// side returns the registered victim and the flush-busy status.
interface plru_victim_ctrl_if #(
  parameter int SETS = 16,
  parameter int WAYS = 8
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             access_valid;
  logic [SET_W-1:0] access_set;
  logic [WAY_W-1:0] access_way;
  logic             victim_req;
  logic [SET_W-1:0] victim_set;
  logic [WAYS-1:0]  inv_mask;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             flush_req;
  logic             busy;

  modport master (
    output access_valid, access_set, access_way,
    output victim_req, victim_set, inv_mask, flush_req,
    input  victim_valid, victim_way, busy
  );

  modport slave (
    input  access_valid, access_set, access_way,
    input  victim_req, victim_set, inv_mask, flush_req,
    output victim_valid, victim_way, busy
  );
endinterface

// File: rtl/plru_victim_ctrl.sv
// Tree pseudo-LRU replacement state for a set-associative cache.
// One (WAYS-1)-bit tree per set: node 0 is the root, children of node a are
// 2a+1 / 2a+2, a 0 bit points left. Hits/fills steer the path away from the
// touched way; victim requests return a registered way one cycle later,
// preferring the lowest-index invalid way. A flush walks every set once.
module plru_victim_ctrl #(
  parameter int SETS = 16,
  parameter int WAYS = 8,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input logic               clk,
  input logic               rst,
  plru_victim_ctrl_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                        state;
  logic [SET_W-1:0]              cnt;
  logic [SETS-1:0][WAYS-2:0]     trees;
  logic                          busy_q;
  logic                          vld_q;
  logic [WAY_W-1:0]              way_q;

  logic [WAYS-2:0]               acc_tree_nxt;
  logic [WAY_W-1:0]              walk_way;
  logic [WAY_W-1:0]              inv_way;
  logic                          any_inv;

  // Point every node on the path to 'way' at the opposite subtree.
  function automatic logic [WAYS-2:0] tree_touch(input logic [WAYS-2:0] t,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    int              idx;
    int              dir;
    r = t;
    for (int l = 0; l < WAY_W; l++) begin
      // Level l starts at node 2^l-1; the top l way bits pick the node in it.
      idx = (1 << l) - 1 + (int'(way) >> (WAY_W - l));
      dir = (int'(way) >> (WAY_W - 1 - l)) & 1;
      for (int n = 0; n < WAYS - 1; n++)
        if (n == idx) r[n] = (dir == 0);
    end
    return r;
  endfunction

  // Follow node bits from the root; the bits read form the way index MSB first.
  function automatic logic [WAY_W-1:0] tree_walk(input logic [WAYS-2:0] t);
    int   node;
    int   acc;
    logic b;
    node = 0;
    acc  = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) b = t[n];
      acc  = (acc << 1) | int'(b);
      node = 2 * node + 1 + int'(b);
    end
    return WAY_W'(acc);
  endfunction

  // Victim candidates are read from the current (pre-update) trees, so a
  // same-cycle access to the same set does not affect this request.
  always_comb begin
    acc_tree_nxt = tree_touch(trees[bus.access_set], bus.access_way);
    walk_way     = tree_walk(trees[bus.victim_set]);
    any_inv      = |bus.inv_mask;
    inv_way      = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (bus.inv_mask[w]) inv_way = WAY_W'(w);
  end

  // Tree storage, flush sequencer and registered victim response.
  always_ff @(posedge clk) begin
    if (rst) begin
      trees  <= '0;
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      way_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_q <= bus.victim_req;
          if (bus.victim_req)
            way_q <= any_inv ? inv_way : walk_way;
          if (bus.flush_req) begin
            // Flush wins over a same-cycle access; the access is dropped.
            state  <= FLUSH;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else if (bus.access_valid) begin
            trees[bus.access_set] <= acc_tree_nxt;
          end
        end
        FLUSH: begin
          vld_q      <= 1'b0;
          trees[cnt] <= '0;
          if (cnt == SET_W'(SETS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.victim_valid = vld_q;
  assign bus.victim_way   = way_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/plru_victim_ctrl.md
Name: plru_victim_ctrl

Overview:
- Sequential tree pseudo-LRU replacement controller for a set-associative cache.
- Holds one (WAYS-1)-bit PLRU tree per set.
- Updates a set's tree on every hit or fill, and returns a registered victim way on request.
- Prefers invalid ways, and supports a multi-cycle flush of all trees.
- Sits beside the tag array in the cache controller, replacing the stand-alone combinational eviction_lru decode.

Parameters:
- SETS, 16, number of cache sets; power of 2, >= 2.
- WAYS, 8, associativity; power of 2, >= 2.
- SET_W, $clog2(SETS), set index width (derived).
- WAY_W, $clog2(WAYS), way index width (derived).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- access_valid  input  1  hit or fill occurred this cycle.
- access_set  input  SET_W  set touched.
- access_way  input  WAY_W  way touched.
- victim_req  input  1  request victim for victim_set.
- victim_set  input  SET_W  set to evict from.
- inv_mask  input  WAYS  bit w=1 means way w of victim_set is invalid; sampled with victim_req.
- victim_valid  output  1  victim_way valid this cycle (1-cycle pulse).
- victim_way  output  WAY_W  selected way.
- flush_req  input  1  clear all PLRU trees.
- busy  output  1  flush in progress.

Behaviour:
- Tree encoding, per set:
  - Node 0 is the root; the children of node a are 2a+1 (left) and 2a+2 (right).
  - Walk: a node bit of 0 goes left, 1 goes right.
  - The victim way index, MSB first, equals the sequence of node bits read along the walk.
- Access update (access_valid=1 in IDLE):
  - For each node on the path to access_way, set the node bit to the inverse of the corresponding access_way bit, so the node points away from that way.
  - Nodes off the path are unchanged.
  - The update is visible from the next cycle.
- Victim selection:
  - If any inv_mask bit is 1, choose the lowest-index invalid way.
  - Otherwise choose the tree-walk result.
  - Selection does not modify the tree; the subsequent fill access updates it.
- Latency: victim_req sampled at edge N drives victim_valid=1 and victim_way during cycle N+1. Back-to-back requests are accepted every cycle.
- Same-cycle access and victim_req to the same set: the victim is computed from the pre-update tree (read-before-write); the access update still commits.
- Same-cycle access and victim_req to different sets: independent.
- FSM has two states, IDLE and FLUSH.
  - IDLE -> FLUSH on flush_req=1. The set counter loads 0 and busy=1 from the next cycle.
  - FLUSH clears one set's tree to all zeros per cycle, counting 0..SETS-1. After clearing set SETS-1 it returns to IDLE; busy=0 in the following cycle. Total busy duration is SETS cycles.
  - In FLUSH, access_valid, victim_req and flush_req are ignored, and victim_valid stays 0.
  - flush_req in the same cycle as access_valid in IDLE: the flush takes priority and the access is dropped.
- Reset:
  - On rst=1, all trees clear to 0 in that edge.
  - FSM goes to IDLE, the counter to 0, busy=0, victim_valid=0, victim_way=0.
  - Reset during a flush aborts it; all trees are still cleared.
  - A victim_req pending in the same cycle as rst is discarded.
- Boundaries:
  - WAYS=2 gives a single-node tree.
  - All ways invalid selects way 0.
  - No wrap-around beyond set SETS-1.
  - Out-of-range values cannot occur since widths are exact.

Test Plan:
- Reset, then victim_req set 3, inv_mask=0 -> next cycle victim_valid=1, victim_way=0; the cycle after, victim_valid=0.
- From reset, access set 5 way 0, then victim_req set 5 -> victim_way=4 (nodes 0, 1, 3 = 1).
- From reset, access set 5 ways 0,1,...,7 on consecutive cycles, then victim_req set 5 -> victim_way=0; set 6 is untouched and also gives 0; accessing way 0 on set 5 afterwards gives victim 4.
- inv_mask=8'b0100_0100 with a tree pointing at way 4 -> victim_way=2.
- Same cycle: access set 2 way 0 plus victim_req set 2, from reset -> victim_way=0; the next victim_req on set 2 gives 4.
- Flush and reset:
  - Populate several sets, then pulse flush_req -> busy=1 for exactly 16 cycles; victim_req and accesses are ignored during busy.
  - After the flush, victim on every set gives 0.
  - rst asserted mid-flush -> busy=0 next cycle and all trees are 0.
